// File: rtl/bs_dat_rnd_sat_pipe_pkg.sv
// Shared constants for the barrel-shift / round / saturate pipeline:
// config byte field positions and output clamp values.
package bs_dat_rnd_sat_pipe_pkg;

  localparam int CFG_SH_LSB = 0;
  localparam int CFG_SH_W   = 6;
  localparam int CFG_RND    = 6;
  localparam int CFG_SAT    = 7;

  // Clamp extremes returned in a wide word; callers slice off the low w bits.
  function automatic logic [63:0] out_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] out_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/bs_dat_rnd_sat_pipe_if.sv
// Input and output beat channels of the pipeline. Both channels use
// valid/ready semantics: a beat moves on a clock edge where *_req & *_ack.
interface bs_dat_rnd_sat_pipe_if #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 16,
  parameter int LANES = 2
);
  logic [LANES*IN_W-1:0]  t_0_dat;
  logic [7:0]             t_cfg_dat;
  logic                   t_0_req;
  logic                   t_0_ack;
  logic [LANES*OUT_W-1:0] i_0_dat;
  logic [LANES-1:0]       i_0_sat;
  logic                   i_0_req;
  logic                   i_0_ack;

  modport master (
    output t_0_dat, t_cfg_dat, t_0_req, i_0_ack,
    input  t_0_ack, i_0_dat, i_0_sat, i_0_req
  );

  modport slave (
    input  t_0_dat, t_cfg_dat, t_0_req, i_0_ack,
    output t_0_ack, i_0_dat, i_0_sat, i_0_req
  );
endinterface

// File: rtl/bs_rnd_sat_lane.sv
// One lane of the datapath: stage 1 registers the rounded word, stage 2
// registers the shifted, optionally clamped sample and its overflow flag.
module bs_rnd_sat_lane
  import bs_dat_rnd_sat_pipe_pkg::*;
#(
  parameter int IN_W  = 36,
  parameter int OUT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                e1,
  input  logic                e2,
  input  logic [IN_W-1:0]     data,
  input  logic [CFG_SH_W-1:0] sh,
  input  logic                round_en,
  input  logic [CFG_SH_W-1:0] sh_s2,
  input  logic                sat_en,
  output logic                ovf,
  output logic [OUT_W-1:0]    out
);
  localparam logic [IN_W:0]  ONE   = 1;
  localparam logic [63:0]    MAX64 = out_max(OUT_W);
  localparam logic [63:0]    MIN64 = out_min(OUT_W);
  localparam logic [OUT_W-1:0] MAXV = MAX64[OUT_W-1:0];
  localparam logic [OUT_W-1:0] MINV = MIN64[OUT_W-1:0];

  logic [IN_W:0]        rnd;
  logic signed [IN_W:0] r_d, r_q, s;
  logic                 ovf_d;
  logic [OUT_W-1:0]     out_d;

  always_comb begin
    rnd = '0;
    if (round_en && sh != '0) rnd = ONE << (sh - 1'b1);
    // One extra bit of headroom so adding the half-LSB cannot overflow.
    r_d = $signed({data[IN_W-1], data}) + $signed(rnd);
    s = r_q >>> sh_s2;
    // Fits in OUT_W bits iff every bit above the output sign bit matches it.
    ovf_d = (s[IN_W:OUT_W-1] != '0) && (s[IN_W:OUT_W-1] != '1);
    out_d = s[OUT_W-1:0];
    if (sat_en && ovf_d) out_d = s[IN_W] ? MINV : MAXV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      ovf <= 1'b0;
      out <= '0;
    end else begin
      if (e1) r_q <= r_d;
      if (e2) begin
        ovf <= ovf_d;
        out <= out_d;
      end
    end
  end
endmodule

// File: rtl/bs_dat_rnd_sat_pipe.sv
// Two-stage multi-lane round / shift / saturate pipeline with flow control
// and a saturating count of delivered beats that overflowed.
module bs_dat_rnd_sat_pipe
  import bs_dat_rnd_sat_pipe_pkg::*;
#(
  parameter int IN_W  = 36,
  parameter int OUT_W = 16,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  bs_dat_rnd_sat_pipe_if.slave bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_cnt
);
  localparam logic [CFG_SH_W-1:0] SH_MAX = CFG_SH_W'(IN_W - 1);

  logic                   v1, v2, e1, e2, ld1, ld2, sat_ev;
  logic [CFG_SH_W-1:0]    cfg_sh, sh, sh2;
  logic                   sat2;
  logic [LANES*OUT_W-1:0] dat_q;
  logic [LANES-1:0]       ovf_q;

  // A stage may load when it is empty or its content is leaving this cycle.
  assign e2  = !v2 || bus.i_0_ack;
  assign e1  = !v1 || e2;
  assign ld1 = e1 && bus.t_0_req && !reset;
  assign ld2 = e2 && v1;

  assign bus.t_0_ack = e1 && !reset;
  assign bus.i_0_req = v2;
  assign bus.i_0_dat = dat_q;
  assign bus.i_0_sat = ovf_q;

  assign cfg_sh = bus.t_cfg_dat[CFG_SH_LSB +: CFG_SH_W];
  assign sh     = (cfg_sh > SH_MAX) ? SH_MAX : cfg_sh;
  assign sat_ev = v2 && bus.i_0_ack && (|ovf_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      sh2     <= '0;
      sat2    <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (e1) v1 <= bus.t_0_req;
      if (e2) v2 <= v1;
      if (ld1) begin
        sh2  <= sh;
        sat2 <= bus.t_cfg_dat[CFG_SAT];
      end
      if (clr_cnt)
        sat_cnt <= sat_ev ? CNT_W'(1) : '0;
      else if (sat_ev && sat_cnt != '1)
        sat_cnt <= sat_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bs_rnd_sat_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .e1       (ld1),
      .e2       (ld2),
      .data     (bus.t_0_dat[k*IN_W +: IN_W]),
      .sh       (sh),
      .round_en (bus.t_cfg_dat[CFG_RND]),
      .sh_s2    (sh2),
      .sat_en   (sat2),
      .ovf      (ovf_q[k]),
      .out      (dat_q[k*OUT_W +: OUT_W])
    );
  end
endmodule
